uart_rx_unit: RTL and testbench

//   Serial receive front end for the processor's peripheral block. Oversamples the UART_RX pin on

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_unit.sv | 158 +++++++++++++++
 tb/tb_uart_rx_unit.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path:
// FSM states, 8N1 frame constants and divider helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_t;

   localparam int   DATA_BITS  = 8;
   localparam int   STOP_BITS  = 1;
   localparam logic IDLE_LEVEL = 1'b1;

   function automatic int calc_div(input int clk_freq,
                                   input int baud,
                                   input int os);
      return clk_freq / (baud * os);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and
// pulses tick on the last count; clr realigns the phase.
module uart_baud_tick #(
   parameter int DIV = 325
) (
   input  logic sysclk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = !clr && (cnt == LAST);

   // free-running divider, held at zero while cleared
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (clr || cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/uart_rx_unit.sv
// UART 8N1 receiver: sync, oversampled frame FSM,
// shift register and one-entry valid/ack holding buffer.
module uart_rx_unit
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       uart_rx,
   input  logic       rx_ack,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_overrun,
   output logic       rx_frame_err
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int TW  = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   rx_state_t     state, state_nxt;
   logic          sync1, rx_s;
   logic          tick;
   logic [TW-1:0] tick_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          deliver;
   logic          half_pt, full_pt;
   logic          clr, cnt_rst, sample_en;
   logic          stop_good, stop_bad;
   logic          take;

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .sysclk (sysclk),
      .reset  (reset),
      .clr    (clr),
      .tick   (tick)
   );

   assign half_pt = tick && (tick_cnt == HALF);
   assign full_pt = tick && (tick_cnt == FULL);

   // two-flop synchronizer, preset to the idle line level
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         sync1 <= IDLE_LEVEL;
         rx_s  <= IDLE_LEVEL;
      end else begin
         sync1 <= uart_rx;
         rx_s  <= sync1;
      end
   end

   // FSM state register
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (!rx_s) state_nxt = START;
         START: if (half_pt) state_nxt = rx_s ? IDLE : DATA;
         DATA:  if (full_pt && bit_cnt == LAST_BIT)
                   state_nxt = STOP;
         STOP:  if (full_pt) state_nxt = rx_s ? IDLE : BREAK;
         BREAK: if (rx_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: divider clear, counter restart, sampling strobes
   always_comb begin
      clr       = 1'b0;
      cnt_rst   = 1'b0;
      sample_en = 1'b0;
      stop_good = 1'b0;
      stop_bad  = 1'b0;
      unique case (state)
         IDLE: begin
            clr     = 1'b1;
            cnt_rst = 1'b1;
         end
         START: cnt_rst = half_pt;
         DATA: begin
            cnt_rst   = full_pt;
            sample_en = full_pt;
         end
         STOP: begin
            cnt_rst   = full_pt;
            stop_good = full_pt && rx_s;
            stop_bad  = full_pt && !rx_s;
         end
         BREAK: cnt_rst = 1'b1;
         default: clr = 1'b1;
      endcase
   end

   // tick and bit counters plus LSB-first shift register
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
      end else begin
         if (cnt_rst)
            tick_cnt <= '0;
         else if (tick)
            tick_cnt <= tick_cnt + 1'b1;
         if (state != DATA)
            bit_cnt <= '0;
         else if (sample_en)
            bit_cnt <= bit_cnt + 1'b1;
         if (sample_en)
            shift[bit_cnt] <= rx_s;
      end
   end

   // a byte is accepted if the buffer is free or freed this cycle
   assign take = deliver && (!rx_valid || rx_ack);

   // holding register and sticky status flags
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         deliver      <= 1'b0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_overrun   <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         deliver <= stop_good;
         if (take)
            rx_data <= shift;
         if (take)
            rx_valid <= 1'b1;
         else if (rx_ack)
            rx_valid <= 1'b0;
         if (deliver && rx_valid && !rx_ack)
            rx_overrun <= 1'b1;
         else if (rx_ack)
            rx_overrun <= 1'b0;
         if (stop_bad)
            rx_frame_err <= 1'b1;
         else if (rx_ack)
            rx_frame_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_unit.sv
// Testbench for uart_rx_unit: directed scenarios plus
// random frames checked against a buffer-level model.
module tb_uart_rx_unit;

   localparam int OS       = 16;
   localparam int BAUD     = 100_000;
   localparam int CLK_FREQ = 16_000_000;
   localparam int DIV      = CLK_FREQ / (BAUD * OS);
   localparam int BIT      = OS * DIV;
   localparam int LAT      = 2 + (OS / 2 + 9 * OS) * DIV + 1;

   logic       sysclk = 1'b0;
   logic       reset  = 1'b0;
   logic       uart_rx = 1'b1;
   logic       rx_ack = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, rx_overrun, rx_frame_err;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model of the one-entry buffer
   logic [7:0] m_data;
   logic       m_valid, m_ovr, m_ferr;

   uart_rx_unit #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OS)
   ) dut (
      .sysclk       (sysclk),
      .reset        (reset),
      .uart_rx      (uart_rx),
      .rx_ack       (rx_ack),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_overrun   (rx_overrun),
      .rx_frame_err (rx_frame_err)
   );

   always #5 sysclk = ~sysclk;

   // called right after a negedge, returns on a negedge
   task automatic send_byte(input logic [7:0] b,
                            input logic stop_ok);
      uart_rx = 1'b0;
      repeat (BIT) @(negedge sysclk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (BIT) @(negedge sysclk);
      end
      uart_rx = stop_ok;
      repeat (BIT) @(negedge sysclk);
      uart_rx = 1'b1;
   endtask

   task automatic pulse_ack();
      @(negedge sysclk);
      rx_ack = 1'b1;
      @(negedge sysclk);
      rx_ack = 1'b0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_ferr  = 1'b0;
   endtask

   task automatic model_frame(input logic [7:0] b,
                              input logic stop_ok);
      if (!stop_ok)
         m_ferr = 1'b1;
      else if (!m_valid) begin
         m_data  = b;
         m_valid = 1'b1;
      end else
         m_ovr = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge sysclk);
      n_checks += 4;
      if (rx_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_data: got %h want 00", rx_data);
      end
      if (rx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid: got %b want 0", rx_valid);
      end
      if (rx_overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ovr: got %b want 0", rx_overrun);
      end
      if (rx_frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ferr: got %b want 0", rx_frame_err);
      end
      reset = 1'b1;
      repeat (4) @(negedge sysclk);
      m_data = 8'h00;
      m_valid = 1'b0;
      m_ovr = 1'b0;
      m_ferr = 1'b0;
   endtask

   task automatic test_single_frame();
      int n;
      n = 0;
      @(negedge sysclk);
      fork
         send_byte(8'hA5, 1'b1);
         begin
            while (rx_valid !== 1'b1 && n < 2 * LAT) begin
               @(posedge sysclk);
               #1;
               n++;
            end
         end
      join
      n_checks += 5;
      if (n < LAT - DIV || n > LAT + DIV) begin
         n_fail++;
         $display("FAIL a5_latency: got %0d want %0d+-%0d", n, LAT, DIV);
      end
      if (rx_data !== 8'hA5) begin
         n_fail++;
         $display("FAIL a5_data: got %h want a5", rx_data);
      end
      if (rx_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL a5_valid: got %b want 1", rx_valid);
      end
      if (rx_overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL a5_ovr: got %b want 0", rx_overrun);
      end
      if (rx_frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL a5_ferr: got %b want 0", rx_frame_err);
      end
      pulse_ack();
   endtask

   task automatic test_glitch();
      @(negedge sysclk);
      uart_rx = 1'b0;
      repeat (BIT / 5) @(negedge sysclk);
      uart_rx = 1'b1;
      repeat (2 * BIT) @(negedge sysclk);
      n_checks += 3;
      if (rx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_valid: got %b want 0", rx_valid);
      end
      if (rx_overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_ovr: got %b want 0", rx_overrun);
      end
      if (rx_frame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch_ferr: got %b want 0", rx_frame_err);
      end
   endtask

   task automatic test_frame_err();
      @(negedge sysclk);
      send_byte(8'h3C, 1'b0);
      repeat (BIT) @(negedge sysclk);
      n_checks += 2;
      if (rx_frame_err !== 1'b1) begin
         n_fail++;
         $display("FAIL ferr_flag: got %b want 1", rx_frame_err);
      end
      if (rx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ferr_valid: got %b want 0", rx_valid);
      end
      send_byte(8'h55, 1'b1);
      repeat (4) @(negedge sysclk);
      n_checks += 2;
      if (rx_data !== 8'h55) begin
         n_fail++;
         $display("FAIL ferr_next_data: got %h want 55", rx_data);
      end
      if (rx_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL ferr_next_valid: got %b want 1", rx_valid);
      end
      pulse_ack();
   endtask

   task automatic test_back_to_back();
      @(negedge sysclk);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      repeat (4) @(negedge sysclk);
      n_checks += 3;
      if (rx_data !== 8'h11) begin
         n_fail++;
         $display("FAIL b2b_data: got %h want 11", rx_data);
      end
      if (rx_overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_ovr: got %b want 1", rx_overrun);
      end
      if (rx_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_valid: got %b want 1", rx_valid);
      end
      pulse_ack();
      @(negedge sysclk);
      n_checks += 2;
      if (rx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_ack_valid: got %b want 0", rx_valid);
      end
      if (rx_overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_ack_ovr: got %b want 0", rx_overrun);
      end
   endtask

   task automatic test_ack_on_delivery();
      @(negedge sysclk);
      send_byte(8'h11, 1'b1);
      repeat (4) @(negedge sysclk);
      fork
         send_byte(8'h7E, 1'b1);
         begin
            repeat (3 + (OS / 2 + 9 * OS) * DIV)
               @(posedge sysclk);
            @(negedge sysclk);
            rx_ack = 1'b1;
            @(negedge sysclk);
            rx_ack = 1'b0;
         end
      join
      n_checks += 3;
      if (rx_data !== 8'h7E) begin
         n_fail++;
         $display("FAIL ackdel_data: got %h want 7e", rx_data);
      end
      if (rx_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL ackdel_valid: got %b want 1", rx_valid);
      end
      if (rx_overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL ackdel_ovr: got %b want 0", rx_overrun);
      end
      pulse_ack();
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] b;
      b = 8'hF0;
      @(negedge sysclk);
      uart_rx = 1'b0;
      repeat (BIT) @(negedge sysclk);
      for (int i = 0; i < 4; i++) begin
         uart_rx = b[i];
         repeat (BIT) @(negedge sysclk);
      end
      uart_rx = b[4];
      repeat (BIT / 2) @(negedge sysclk);
      reset = 1'b0;
      uart_rx = 1'b1;
      repeat (5) @(negedge sysclk);
      reset = 1'b1;
      repeat (12 * BIT) @(negedge sysclk);
      n_checks += 1;
      if (rx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_valid: got %b want 0", rx_valid);
      end
      send_byte(8'h0F, 1'b1);
      repeat (4) @(negedge sysclk);
      n_checks += 2;
      if (rx_data !== 8'h0F) begin
         n_fail++;
         $display("FAIL rstmid_data: got %h want 0f", rx_data);
      end
      if (rx_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_valid2: got %b want 1", rx_valid);
      end
      pulse_ack();
   endtask

   task automatic test_random();
      logic [7:0] b;
      logic       ok;
      for (int k = 0; k < 8; k++) begin
         b  = 8'($urandom);
         ok = ($urandom_range(0, 3) != 0);
         @(negedge sysclk);
         send_byte(b, ok);
         model_frame(b, ok);
         repeat (6) @(negedge sysclk);
         if ($urandom_range(0, 1) == 1)
            pulse_ack();
         @(negedge sysclk);
         n_checks += 4;
         if (rx_valid !== m_valid) begin
            n_fail++;
            $display("FAIL rnd%0d_valid: got %b want %b", k, rx_valid, m_valid);
         end
         if (m_valid && rx_data !== m_data) begin
            n_fail++;
            $display("FAIL rnd%0d_data: got %h want %h", k, rx_data, m_data);
         end
         if (rx_overrun !== m_ovr) begin
            n_fail++;
            $display("FAIL rnd%0d_ovr: got %b want %b", k, rx_overrun, m_ovr);
         end
         if (rx_frame_err !== m_ferr) begin
            n_fail++;
            $display("FAIL rnd%0d_ferr: got %b want %b", k, rx_frame_err, m_ferr);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_ack_on_delivery();
      test_reset_mid_frame();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
